// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// Requests use a valid/ready handshake. Responses come back in request order and
// cannot be back-pressured.
interface ifetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC and issues in-order requests to a variable-latency
// imem. It buffers returned words in a small FIFO and presents the head instruction with
// its decode slices. Redirects flush the buffer and drop wrong-path responses that are
// still in flight.
// Optional build macro: IFETCH_PERF_CNT_EN adds the perf_fetched/perf_flushed counters.
module ifetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  ifetch_unit_if.master imem,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic [6:0]   opcode,
  output logic [2:0]   funct3,
  output logic [6:0]   funct7,
  output logic [4:0]   rd,
  output logic [4:0]   rs1,
  output logic [11:0]  imm
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_flushed
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;

  // PCs of outstanding requests. Responses return in order, so this is a plain ring.
  logic [31:0]   pcq [FIFO_DEPTH];
  logic [AW-1:0] pcq_wr, pcq_rd;

  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] fifo_wr, fifo_rd;
  logic [CW-1:0] fifo_cnt;

  logic credit, req_fire, rsp, push, pop;

  // The low redirect bits are ignored because fetch addresses are always word aligned.
  logic unused_rpc_lo;
  assign unused_rpc_lo = ^redirect_pc[1:0];

  // Credit covers both in-flight requests and buffered words, so a response always has room.
  always_comb begin
    credit   = ((CW+1)'(inflight) + (CW+1)'(fifo_cnt)) < (CW+1)'(FIFO_DEPTH);
    // Gating with reset keeps the request low while the block is held in reset.
    imem.req_valid = reset && !redirect && credit;
    imem.req_addr  = fetch_pc;
    req_fire = imem.req_valid && imem.req_ready;
    rsp      = imem.rsp_valid;
    push     = rsp && !redirect && (drop_cnt == '0);
    pop      = inst_valid && inst_ready;
  end

  // Head-of-buffer presentation and decode slices.
  always_comb begin
    inst_valid = (fifo_cnt != '0);
    inst       = inst_valid ? fifo_data[fifo_rd] : NOP;
    inst_pc    = inst_valid ? fifo_pc[fifo_rd] : 32'h0;
    opcode     = inst[6:0];
    funct3     = inst[14:12];
    funct7     = inst[31:25];
    rd         = inst[11:7];
    rs1        = inst[19:15];
    imm        = inst[31:20];
  end

  // Storage arrays. The pointers and credit accounting keep write and read slots apart.
  always_ff @(posedge clk) begin
    if (req_fire) pcq[pcq_wr] <= fetch_pc;
    if (push) begin
      fifo_data[fifo_wr] <= imem.rsp_data;
      fifo_pc[fifo_wr]   <= pcq[pcq_rd];
    end
  end

  // PC, in-flight accounting, drop counter and FIFO pointers. Redirect overrides the rest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= PC_RESET;
      inflight <= '0;
      drop_cnt <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (req_fire) begin
        pcq_wr   <= pcq_wr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp) pcq_rd <= pcq_rd + AW'(1);
      inflight <= inflight + CW'(req_fire) - CW'(rsp);

      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        fifo_wr  <= '0;
        fifo_rd  <= '0;
        fifo_cnt <= '0;
        // Every request still outstanding after this cycle belongs to the wrong path.
        drop_cnt <= inflight - CW'(rsp);
      end else begin
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) fifo_wr <= fifo_wr + AW'(1);
        if (pop)  fifo_rd <= fifo_rd + AW'(1);
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Counters for consumed instructions and for wrong-path work thrown away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop && !redirect) perf_fetched <= perf_fetched + 32'd1;
      if (redirect)
        perf_flushed <= perf_flushed + 32'(fifo_cnt) + 32'(rsp);
      else if (rsp && (drop_cnt != '0))
        perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by randomized traffic.
// The reference model treats the fetch stream as "consecutive PCs starting at the last
// reset/redirect target". The variable-latency imem returns a fixed function of the address.
module tb_ifetch_unit;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1;
  logic [11:0] imm;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  ifetch_unit_if imem ();

  ifetch_unit #(.PC_RESET(PC_RESET), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem(imem),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .imm(imm)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0013;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // imem model and reference state
  int          rsp_due[$];
  logic [31:0] rsp_word[$];
  int          last_due;
  int          lat_lo = 1, lat_hi = 1;
  logic [31:0] exp_req_pc, exp_pop_pc;
  int          req_since, pop_since, pops_total, hs_count, first_hs, first_iv;
  bit          hs_now;
  logic [31:0] hs_addr;

  logic        d_redirect = 1'b0, d_iready = 1'b0, d_qready = 1'b0;
  logic [31:0] d_rpc = 32'h0;
  bit          rand_mode = 1'b0, redir_on_busy = 1'b0, busy_hit = 1'b0;
  logic [31:0] busy_target = 32'h0;

  task automatic model_clear(logic [31:0] start);
    exp_req_pc = start;
    exp_pop_pc = start;
    req_since  = 0;
    pop_since  = 0;
  endtask

  task automatic check_cycle();
    logic [31:0] w;
    hs_now = 1'b0;
    if (!inst_valid) begin
      chk("idle_inst", inst, 32'h0000_0013);
      chk("idle_pc", inst_pc, 32'h0);
    end else if (first_iv < 0) begin
      first_iv = cyc;
    end
    if (redirect) begin
      chk("redir_noreq", 32'(imem.req_valid), 32'd0);
      model_clear({redirect_pc[31:2], 2'b00});
    end else begin
      if (imem.req_valid && imem.req_ready) begin
        int k, due;
        chk("req_addr", imem.req_addr, exp_req_pc);
        chk("credit", 32'(req_since - pop_since < DEPTH), 32'd1);
        k = $urandom_range(lat_hi, lat_lo);
        due = cyc + k;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rsp_due.push_back(due);
        rsp_word.push_back(mem_word(imem.req_addr));
        hs_now = 1'b1;
        hs_addr = imem.req_addr;
        hs_count++;
        if (first_hs < 0) first_hs = cyc;
        exp_req_pc += 32'd4;
        req_since++;
      end
      if (inst_valid && inst_ready) begin
        w = mem_word(exp_pop_pc);
        chk("pop_pc", inst_pc, exp_pop_pc);
        chk("pop_inst", inst, w);
        chk("fields", {funct7, 5'd0, rs1, funct3, rd, opcode}, w & 32'hFE0F_FFFF);
        chk("imm", 32'(imm), 32'(w[31:20]));
        exp_pop_pc += 32'd4;
        pop_since++;
        pops_total++;
      end
    end
  endtask

  task automatic step();
    bit trig;
    trig = 1'b0;
    @(posedge clk);
    #1;
    if (rand_mode) begin
      d_qready   = ($urandom_range(0, 3) != 0);
      d_iready   = ($urandom_range(0, 9) < 7);
      d_redirect = ($urandom_range(0, 29) == 0);
      d_rpc      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : 32'($urandom_range(0, 1023));
    end
    imem.req_ready = d_qready;
    inst_ready     = d_iready;
    if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = rsp_word[0];
      void'(rsp_due.pop_front());
      void'(rsp_word.pop_front());
    end else begin
      imem.rsp_valid = 1'b0;
      imem.rsp_data  = $urandom;
    end
    if (redir_on_busy && imem.rsp_valid && inst_valid && d_iready) begin
      d_redirect    = 1'b1;
      d_rpc         = busy_target;
      redir_on_busy = 1'b0;
      busy_hit      = 1'b1;
      trig          = 1'b1;
    end
    redirect    = d_redirect;
    redirect_pc = d_rpc;
    @(negedge clk);
    check_cycle();
    if (trig) d_redirect = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect       = 1'b0;
    inst_ready     = 1'b0;
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = 32'h0;
    d_redirect = 1'b0; d_iready = 1'b0; d_qready = 1'b0;
    rsp_due.delete();
    rsp_word.delete();
    last_due   = 0;
    pops_total = 0;
    hs_count   = 0;
    first_hs   = -1;
    first_iv   = -1;
    model_clear(PC_RESET);
    #1;
    chk("rst_ivalid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_reqv", 32'(imem.req_valid), 32'd0);
    chk("rst_addr", imem.req_addr, PC_RESET);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_perf_f", perf_fetched, 32'd0);
    chk("rst_perf_x", perf_flushed, 32'd0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fl0;
`endif

    // 1: streaming with a 1-cycle imem
    do_reset();
    lat_lo = 1; lat_hi = 1;
    d_qready = 1'b1; d_iready = 1'b1;
    repeat (12) step();
    chk("t1_latency", 32'(first_iv - first_hs), 32'd2);
    chk("t1_first_hs", 32'(first_hs >= 0), 32'd1);
    chk("t1_pops", 32'(pops_total >= 4), 32'd1);

    // 2: consumer stalled, then released
    do_reset();
    d_qready = 1'b1; d_iready = 1'b0;
    repeat (10) step();
    chk("t2_reqs", 32'(hs_count), 32'(DEPTH));
    chk("t2_reqv", 32'(imem.req_valid), 32'd0);
    chk("t2_full", 32'(inst_valid), 32'd1);
    d_iready = 1'b1;
    repeat (10) step();
    chk("t2_drain", 32'(pops_total >= 4), 32'd1);

    // 3: redirect with two requests in flight, 3-cycle imem
    do_reset();
    lat_lo = 3; lat_hi = 3;
    d_qready = 1'b1; d_iready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (rsp_due.size() == 2) found = 1'b1;
    end
    chk("t3_two_inflight", 32'(found), 32'd1);
    chk("t3_empty", 32'(inst_valid), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    fl0 = perf_flushed;
`endif
    d_redirect = 1'b1; d_rpc = 32'h100;
    step();
    d_redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (inst_valid) found = 1'b1;
    end
    chk("t3_found", 32'(found), 32'd1);
    chk("t3_pc", inst_pc, 32'h100);
`ifdef IFETCH_PERF_CNT_EN
    chk("t3_flushed", perf_flushed - fl0, 32'd2);
`endif

    // 4: redirect coinciding with a response and a pop
    do_reset();
    lat_lo = 1; lat_hi = 1;
    d_qready = 1'b1; d_iready = 1'b1;
    busy_target = 32'h300; busy_hit = 1'b0; redir_on_busy = 1'b1;
    for (int i = 0; i < 20 && !busy_hit; i++) step();
    redir_on_busy = 1'b0;
    chk("t4_hit", 32'(busy_hit), 32'd1);
    step();
    chk("t4_empty", 32'(inst_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (inst_valid) found = 1'b1;
    end
    chk("t4_found", 32'(found), 32'd1);
    chk("t4_pc", inst_pc, 32'h300);

    // 5: unaligned redirect target and PC wrap
    d_redirect = 1'b1; d_rpc = 32'h203;
    step();
    d_redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = hs_now;
    end
    chk("t5_hs", 32'(found), 32'd1);
    chk("t5_align", hs_addr, 32'h200);
    d_redirect = 1'b1; d_rpc = 32'hFFFF_FFFE;
    step();
    d_redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = hs_now;
    end
    chk("t5_top_hs", 32'(found), 32'd1);
    chk("t5_top", hs_addr, 32'hFFFF_FFFC);
    step();
    chk("t5_wrap", imem.req_addr, 32'h0);
    repeat (10) step();

    // 6: reset with a buffered word and a response in flight
    do_reset();
    lat_lo = 3; lat_hi = 3;
    d_qready = 1'b1; d_iready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (inst_valid && (rsp_due.size() > 0 || imem.rsp_valid)) found = 1'b1;
    end
    chk("t6_busy", 32'(found), 32'd1);
    do_reset();
    d_qready = 1'b1; d_iready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = hs_now;
    end
    chk("t6_hs", 32'(found), 32'd1);
    chk("t6_first_addr", hs_addr, PC_RESET);

    // randomized traffic
    do_reset();
    lat_lo = 1; lat_hi = 4;
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    d_redirect = 1'b0;
    chk("rand_pops", 32'(pops_total > 200), 32'd1);
`ifdef IFETCH_PERF_CNT_EN
    chk("rand_perf_fetched", perf_fetched, 32'(pops_total));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
